// File: rtl/keypad_pkg.sv
// Shared state type and sizing helpers for the matrix keypad scanner.
package keypad_pkg;

    // SETTLE: row settling | SAMPLE: read columns | DEBOUNCE: press check | REPORT: event pending | HELD: wait release
    typedef enum logic [2:0] {SETTLE, SAMPLE, DEBOUNCE, REPORT, HELD} state_t;

    function automatic int code_width(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

    function automatic int timer_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keypad_timer.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module keypad_timer
    import keypad_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/keypad_scanner.sv
// Row/column keypad scanner with single-timer debounce and valid/ready key events.
// Optional auto-repeat while held: define KEYPAD_SCANNER_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int   ROWS            = 4,
    parameter int   COLS            = 4,
    parameter int   SETTLE_CYCLES   = 16,
    parameter int   DEBOUNCE_CYCLES = 1000,
    parameter logic COL_IDLE        = 1'b1
`ifdef KEYPAD_SCANNER_REPEAT_EN
    ,
    parameter int   REPEAT_DELAY    = 50000,
    parameter int   REPEAT_PERIOD   = 10000
`endif
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic [ROWS-1:0]                     row_drive,
    input  logic [COLS-1:0]                     col_in,
    output logic [code_width(ROWS, COLS)-1:0]   key_code,
    output logic                                key_valid,
    input  logic                                key_ready,
    output logic                                key_held
);

    localparam int RW  = $clog2(ROWS);
    localparam int CIW = $clog2(COLS);
    localparam int CW  = code_width(ROWS, COLS);
`ifdef KEYPAD_SCANNER_REPEAT_EN
    localparam int TMAX = max2(max2(SETTLE_CYCLES, DEBOUNCE_CYCLES), max2(REPEAT_DELAY, REPEAT_PERIOD));
`else
    localparam int TMAX = max2(SETTLE_CYCLES, DEBOUNCE_CYCLES);
`endif
    localparam int TW = timer_width(TMAX);

    localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] T_DEB    = TW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
`ifdef KEYPAD_SCANNER_REPEAT_EN
    localparam logic [TW-1:0] T_RDLY   = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] T_RPER   = TW'(REPEAT_PERIOD);
    localparam logic [TW-1:0] T_HELD   = T_RDLY;
`else
    localparam logic [TW-1:0] T_HELD   = T_DEB;
`endif

    state_t          state;
    logic [RW-1:0]   row;
    logic [CIW-1:0]  col_q;
    logic            rel_phase;

    logic            tmr_load;
    logic            tmr_dec;
    logic [TW-1:0]   tmr_val;
    logic [TW-1:0]   count;
    logic            zero;

    logic [COLS-1:0] active;
    logic [COLS-1:0] col_mask;
    logic [CIW-1:0]  low_col;
    logic            any_act;
    logic            exact;
    logic            hit;
    logic            expire;
    logic            pending;
    logic            accept;
    logic [TW-1:0]   rel_val;
    logic            rel_done;

    function automatic logic [ROWS-1:0] row_pattern(input logic [RW-1:0] r);
        logic [ROWS-1:0] p;
        p    = {ROWS{COL_IDLE}};
        p[r] = ~COL_IDLE;
        return p;
    endfunction

    function automatic logic [RW-1:0] next_row(input logic [RW-1:0] r);
        return (r == RW'(ROWS - 1)) ? '0 : r + 1'b1;
    endfunction

    keypad_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .count    (count),
        .zero     (zero)
    );

    assign active   = col_in ^ {COLS{COL_IDLE}};
    assign any_act  = |active;
    assign col_mask = COLS'(1) << col_q;
    assign exact    = (active == col_mask);
    assign hit      = active[col_q];
    assign expire   = zero || (count == T_ONE);
    assign pending  = key_valid && !key_ready;
    assign accept   = key_valid && key_ready;
    // Release timing reuses the timer; the first inactive cycle behaves as if DEBOUNCE was loaded.
    assign rel_val  = rel_phase ? count : T_DEB;
    assign rel_done = (rel_val <= T_ONE);

    always_comb begin
        low_col = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (active[i]) low_col = i[CIW-1:0];
        end
    end

    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = count;
        case (state)
            SETTLE:   tmr_dec = 1'b1;
            SAMPLE: begin
                tmr_load = 1'b1;
                tmr_val  = any_act ? T_DEB : T_SETTLE;
            end
            DEBOUNCE: begin
                if (!exact) begin
                    tmr_load = 1'b1;
                    tmr_val  = T_SETTLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            REPORT: begin
                if (accept) begin
                    tmr_load = 1'b1;
                    tmr_val  = T_HELD;
                end
            end
            HELD: begin
                if (hit) begin
`ifdef KEYPAD_SCANNER_REPEAT_EN
                    if (rel_phase) begin
                        tmr_load = 1'b1;
                        tmr_val  = T_RDLY;
                    end else if (!pending) begin
                        if (expire) begin
                            tmr_load = 1'b1;
                            tmr_val  = T_RPER;
                        end else begin
                            tmr_dec = 1'b1;
                        end
                    end
`endif
                end else begin
                    tmr_load = 1'b1;
                    if (rel_done) tmr_val = pending ? rel_val : T_SETTLE;
                    else          tmr_val = rel_val - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SETTLE;
            row       <= '0;
            row_drive <= row_pattern('0);
            col_q     <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            rel_phase <= 1'b0;
        end else begin
            case (state)
                SETTLE: begin
                    if (expire) state <= SAMPLE;
                end
                SAMPLE: begin
                    if (any_act) begin
                        col_q    <= low_col;
                        key_code <= CW'(int'(row) * COLS + int'(low_col));
                        state    <= DEBOUNCE;
                    end else begin
                        row       <= next_row(row);
                        row_drive <= row_pattern(next_row(row));
                        state     <= SETTLE;
                    end
                end
                DEBOUNCE: begin
                    if (!exact) begin
                        state <= SETTLE;
                    end else if (expire) begin
                        key_valid <= 1'b1;
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    if (accept) begin
                        key_valid <= 1'b0;
                        key_held  <= 1'b1;
                        rel_phase <= 1'b0;
                        state     <= HELD;
                    end
                end
                HELD: begin
                    if (accept) key_valid <= 1'b0;
                    if (hit) begin
                        rel_phase <= 1'b0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
                        if (!rel_phase && !pending && expire) key_valid <= 1'b1;
`endif
                    end else begin
                        rel_phase <= 1'b1;
                        // Never leave with an event outstanding, or key_code could be overwritten.
                        if (rel_done && !pending) begin
                            key_held  <= 1'b0;
                            row       <= next_row(row);
                            row_drive <= row_pattern(next_row(row));
                            state     <= SETTLE;
                        end
                    end
                end
                default: state <= SETTLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: vector table, corner sequences and randomized presses.
module tb_keypad_scanner;

    localparam int   ROWS   = 4;
    localparam int   COLS   = 4;
    localparam int   SETTLE = 2;
    localparam int   DEB    = 8;
    localparam logic IDLE   = 1'b1;
    localparam int   CW     = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [ROWS-1:0]      row_drive;
    logic [COLS-1:0]      col_in;
    logic [CW-1:0]        key_code;
    logic                 key_valid;
    logic                 key_ready = 1'b0;
    logic                 key_held;
    logic [ROWS*COLS-1:0] pressed = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [CW-1:0] ev_q[$];

    keypad_scanner #(
        .ROWS            (ROWS),
        .COLS            (COLS),
        .SETTLE_CYCLES   (SETTLE),
        .DEBOUNCE_CYCLES (DEB),
        .COL_IDLE        (IDLE)
`ifdef KEYPAD_SCANNER_REPEAT_EN
        ,
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (10)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_drive (row_drive),
        .col_in    (col_in),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A pressed switch shorts its column to the row only while that row is strobed.
    always_comb begin
        col_in = {COLS{IDLE}};
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (pressed[r*COLS+c] && (row_drive[r] == ~IDLE)) col_in[c] = ~IDLE;
    end

    always @(posedge clk) if (!rst && key_valid && key_ready) ev_q.push_back(key_code);

    typedef struct {
        int r;
        int c;
        int rdy_wait;
        int code;
    } vec_t;

    function automatic logic [ROWS-1:0] pat(input int r);
        logic [ROWS-1:0] p;
        p    = {ROWS{IDLE}};
        p[r] = ~IDLE;
        return p;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_valid(input int limit, output int ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            if (key_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Press while the scan is elsewhere, so the latency from row selection is deterministic.
    task automatic press_and_wait(input int r, input int c, output int lat);
        int t0;
        lat = -1;
        t0  = -1;
        for (int i = 0; i < 200 && row_drive == pat(r); i++) @(negedge clk);
        pressed[r*COLS+c] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (row_drive == pat(r)) begin
                t0 = cyc;
                break;
            end
        end
        for (int i = 0; i < 200 && t0 >= 0; i++) begin
            if (key_valid) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic accept_key();
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    task automatic release_and_time(output int d);
        pressed = '0;
        d = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (!key_held) begin
                d = i;
                break;
            end
        end
    endtask

    initial begin
        vec_t tbl[4];
        int lat, d, ok, n0, cnt, trans, idx;
        logic [ROWS-1:0] prev;
        logic [ROWS-1:0] seq [4];

        tbl[0] = '{r: 2, c: 1, rdy_wait: 0, code: 9};
        tbl[1] = '{r: 0, c: 0, rdy_wait: 3, code: 0};
        tbl[2] = '{r: 3, c: 3, rdy_wait: 7, code: 15};
        tbl[3] = '{r: 1, c: 2, rdy_wait: 1, code: 6};
        seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_row_drive", row_drive, 4'b1110);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        check("rst_code", key_code, 0);
        rst = 1'b0;

        // Idle scan order
        prev = row_drive; idx = 0; trans = 0; cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (key_valid) cnt++;
            if (row_drive != prev) begin
                idx = (idx + 1) % 4;
                trans++;
                check("idle_row_seq", row_drive, seq[idx]);
                prev = row_drive;
            end
        end
        check("idle_enough_rows", (trans >= 5) ? 1 : 0, 1);
        check("idle_no_valid", cnt, 0);

        // Table of single stable presses
        foreach (tbl[i]) begin
            n0 = ev_q.size();
            press_and_wait(tbl[i].r, tbl[i].c, lat);
            check("press_latency", lat, SETTLE + DEB + 1);
            check("press_code", key_code, tbl[i].code);
            repeat (tbl[i].rdy_wait) @(negedge clk);
            check("valid_held_until_ready", key_valid, 1);
            check("code_stable", key_code, tbl[i].code);
            accept_key();
            check("held_after_accept", key_held, 1);
            check("valid_cleared", key_valid, 0);
            repeat (5) @(negedge clk);
            release_and_time(d);
            check("release_debounce", d, DEB);
            check("one_event", ev_q.size() - n0, 1);
        end

        // Bouncing r1c3 then stable
        n0 = ev_q.size(); cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) pressed[1*COLS+3] = ~pressed[1*COLS+3];
            @(negedge clk);
            if (key_valid) cnt++;
        end
        check("bounce_no_early_valid", cnt, 0);
        pressed[1*COLS+3] = 1'b1;
        wait_valid(300, ok);
        check("bounce_valid_seen", ok, 1);
        check("bounce_code", key_code, 7);
        accept_key();
        repeat (4) @(negedge clk);
        release_and_time(d);
        check("bounce_one_event", ev_q.size() - n0, 1);

        // r0c0 released before acceptance
        press_and_wait(0, 0, lat);
        pressed = '0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!key_valid || key_code != 0) cnt++;
        end
        check("pending_survives_release", cnt, 0);
        accept_key();
        check("late_accept_held", key_held, 1);
        release_and_time(d);
        check("late_accept_release", d, DEB);

        // Two keys on row 3
        for (int i = 0; i < 200 && row_drive == pat(3); i++) @(negedge clk);
        pressed[3*COLS+0] = 1'b1;
        pressed[3*COLS+2] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (key_valid) cnt++;
        end
        check("multikey_no_report", cnt, 0);
        pressed[3*COLS+0] = 1'b0;
        wait_valid(200, ok);
        check("multikey_valid", ok, 1);
        check("multikey_code", key_code, 14);
        accept_key();
        release_and_time(d);
        check("multikey_release", d, DEB);

        // Reset while reporting
        press_and_wait(2, 1, lat);
        check("pre_rst_valid", key_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_drops_valid", key_valid, 0);
        check("rst_row_drive_mid", row_drive, 4'b1110);
        @(negedge clk);
        pressed = '0;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (key_valid) cnt++;
        end
        check("post_rst_quiet", cnt, 0);

        // Randomized presses with bounce and random consumer delay
        for (int k = 0; k < 10; k++) begin
            int r, c, nb;
            r  = $urandom_range(0, ROWS - 1);
            c  = $urandom_range(0, COLS - 1);
            nb = $urandom_range(0, 3);
            n0 = ev_q.size();
            for (int b = 0; b < nb; b++) begin
                pressed[r*COLS+c] = 1'b1;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                pressed[r*COLS+c] = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
            pressed[r*COLS+c] = 1'b1;
            wait_valid(400, ok);
            check("rand_valid", ok, 1);
            repeat ($urandom_range(0, 6)) @(negedge clk);
            accept_key();
            repeat ($urandom_range(0, 10)) @(negedge clk);
            release_and_time(d);
            check("rand_release", d, DEB);
            check("rand_event_count", ev_q.size() - n0, 1);
            if (ev_q.size() > 0) check("rand_event_code", ev_q[ev_q.size()-1], r * COLS + c);
        end

`ifdef KEYPAD_SCANNER_REPEAT_EN
        begin
            int t_h, nrise;
            int rises[3];
            logic prev_v;
            press_and_wait(1, 1, lat);
            key_ready = 1'b1;
            @(negedge clk);
            t_h = cyc;
            check("repeat_held", key_held, 1);
            prev_v = key_valid;
            nrise = 0;
            for (int i = 0; i < 45; i++) begin
                @(negedge clk);
                if (key_valid && !prev_v && nrise < 3) begin
                    rises[nrise] = cyc - t_h;
                    nrise++;
                end
                prev_v = key_valid;
            end
            check("repeat_count", nrise, 3);
            for (int i = 0; i < 3; i++) check("repeat_time", (i < nrise) ? rises[i] : -1, 20 + 10 * i);
            release_and_time(d);
            check("repeat_release", d, DEB);
            key_ready = 1'b0;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
